// File: rtl/gate_bist_pkg.sv
// Shared types and helpers for the inverter-bank BIST controller.
// GATE_BIST_EXHAUSTIVE_EN appends a full binary count to the vector set.
package gate_bist_pkg;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      WAIT,
      CHECK,
      DONE
   } state_t;

   typedef enum logic [2:0] {
      ZERO,
      ONE,
      WALK1,
      WALK0,
      EXH
   } phase_t;

   function automatic int vec_count(input int width);
`ifdef GATE_BIST_EXHAUSTIVE_EN
      return 2 + 2 * width + (1 << width);
`else
      return 2 + 2 * width;
`endif
   endfunction

endpackage

// File: rtl/gate_bist_pattern.sv
// Stimulus sequencer: zero, one, walking-1, walking-0 and, with
// GATE_BIST_EXHAUSTIVE_EN, an ascending count over all values.
module gate_bist_pattern #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   input  logic             next,
   output logic [WIDTH-1:0] vec,
   output logic             last_vec
);
   import gate_bist_pkg::*;

`ifdef GATE_BIST_EXHAUSTIVE_EN
   localparam int IW = WIDTH;
`else
   localparam int IW = (WIDTH < 2) ? 1 : $clog2(WIDTH);
`endif
   localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

`ifdef GATE_BIST_EXHAUSTIVE_EN
   if (WIDTH > 16) begin : g_width_chk
      $error("gate_bist_pattern: exhaustive mode needs WIDTH <= 16");
   end
`endif

   phase_t        phase;
   logic [IW-1:0] idx;
   logic          idx_top;

   assign idx_top = (idx == IDX_TOP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= ZERO;
         idx   <= '0;
      end else if (restart) begin
         phase <= ZERO;
         idx   <= '0;
      end else if (next) begin
         unique case (phase)
            ZERO: phase <= ONE;
            ONE: begin
               phase <= WALK1;
               idx   <= '0;
            end
            WALK1: begin
               if (idx_top) begin
                  phase <= WALK0;
                  idx   <= '0;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            WALK0: begin
               if (idx_top) begin
`ifdef GATE_BIST_EXHAUSTIVE_EN
                  phase <= EXH;
                  idx   <= '0;
`else
                  idx   <= idx;
`endif
               end else begin
                  idx <= idx + IW'(1);
               end
            end
`ifdef GATE_BIST_EXHAUSTIVE_EN
            EXH: idx <= idx + IW'(1);
`endif
            default: phase <= ZERO;
         endcase
      end
   end

   always_comb begin
      vec = '0;
      unique case (phase)
         ZERO:  vec = '0;
         ONE:   vec = '1;
         WALK1: vec = WIDTH'(1) << idx;
         WALK0: vec = ~(WIDTH'(1) << idx);
`ifdef GATE_BIST_EXHAUSTIVE_EN
         EXH:   vec = WIDTH'(idx);
`endif
         default: vec = '0;
      endcase
   end

`ifdef GATE_BIST_EXHAUSTIVE_EN
   assign last_vec = (phase == EXH) && (&idx);
`else
   assign last_vec = (phase == WALK0) && idx_top;
`endif

endmodule

// File: rtl/gate_not_bist.sv
// BIST controller for an inverter bank: applies vectors, checks resp == ~stim.
// GATE_BIST_EXHAUSTIVE_EN adds the exhaustive count phase (WIDTH <= 16).
module gate_not_bist #(
   parameter int WIDTH  = 8,
   parameter int SETTLE = 2,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [WIDTH-1:0] stim,
   input  logic [WIDTH-1:0] resp,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [WIDTH-1:0] first_fail
);
   import gate_bist_pkg::*;

   localparam int CW = $clog2(SETTLE + 1);
   localparam logic [CW-1:0] WAIT_END = CW'((SETTLE > 1) ? SETTLE - 2 : 0);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic          last_vec;
   logic          restart;
   logic          next;
   logic          check;
   logic          fail;

   gate_bist_pattern #(
      .WIDTH(WIDTH)
   ) u_pattern (
      .clk      (clk),
      .reset    (reset),
      .restart  (restart),
      .next     (next),
      .vec      (stim),
      .last_vec (last_vec)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // CHECK is the final settle cycle; its closing edge compares and advances
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, DONE: if (start) state_nxt = APPLY;
         APPLY:      state_nxt = (SETTLE > 1) ? WAIT : CHECK;
         WAIT:       if (cnt == WAIT_END) state_nxt = CHECK;
         CHECK:      state_nxt = last_vec ? DONE : APPLY;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state == APPLY) || (state == WAIT) || (state == CHECK);
      done    = (state == DONE);
      restart = ((state == IDLE) || (state == DONE)) && start;
      check   = (state == CHECK);
      next    = check && !last_vec;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)              cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CW'(1);
      else                    cnt <= '0;
   end

   assign fail = (resp != ~stim);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_count  <= '0;
         first_fail <= '0;
         pass       <= 1'b0;
      end else if (restart) begin
         err_count  <= '0;
         first_fail <= '0;
         pass       <= 1'b0;
      end else if (check) begin
         if (fail) begin
            if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
            if (err_count == '0)      first_fail <= stim;
         end
         if (last_vec) pass <= (err_count == '0) && !fail;
      end
   end

endmodule

// File: tb/tb_gate_not_bist.sv
// Directed bench for gate_not_bist: good, stuck-at, buffer, reset, restart.
// Exhaustive-mode instance is built when GATE_BIST_EXHAUSTIVE_EN is defined.
module tb_gate_not_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       start;
   logic [7:0] stim;
   logic [7:0] resp;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;
   logic [7:0] first_fail;
   int         mode;

   always_comb begin
      case (mode)
         1:       resp = ~stim & 8'hF7;
         2:       resp = stim;
         default: resp = ~stim;
      endcase
   end

   gate_not_bist #(.WIDTH(8), .SETTLE(2), .ERR_W(8)) u_dut (
      .clk(clk), .reset(reset), .start(start), .stim(stim), .resp(resp),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .first_fail(first_fail)
   );

   logic       start4;
   logic [7:0] stim4;
   logic       busy4;
   logic       done4;
   logic       pass4;
   logic [3:0] err4;
   logic [7:0] ff4;

   gate_not_bist #(.WIDTH(8), .SETTLE(2), .ERR_W(4)) u_dut4 (
      .clk(clk), .reset(reset), .start(start4), .stim(stim4), .resp(stim4),
      .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
      .first_fail(ff4)
   );

`ifdef GATE_BIST_EXHAUSTIVE_EN
   logic       startx;
   logic [3:0] stimx;
   logic [3:0] respx;
   logic       busyx;
   logic       donex;
   logic       passx;
   logic [7:0] errx;
   logic [3:0] ffx;
   logic [3:0] logx [0:127];

   assign respx = ~stimx;

   gate_not_bist #(.WIDTH(4), .SETTLE(2), .ERR_W(8)) u_dutx (
      .clk(clk), .reset(reset), .start(startx), .stim(stimx), .resp(respx),
      .busy(busyx), .done(donex), .pass(passx), .err_count(errx),
      .first_fail(ffx)
   );
`endif

   int         total;
   int         bad;
   logic [7:0] stim_log [0:63];
   logic       busy_at0;
   logic       done_at0;
   int         cyc;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // start edge is cycle 0; counts edges until done is seen
   task automatic run_main(input int extra_at, output int n);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      busy_at0    = busy;
      done_at0    = done;
      stim_log[0] = stim;
      n = 0;
      while (!done && n < 300) begin
         @(negedge clk) start = (n == extra_at);
         @(posedge clk);
         #1 n++;
         if (n < 64) stim_log[n] = stim;
      end
      start = 1'b0;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      mode   = 0;
      reset  = 1'b1;
      start  = 1'b0;
      start4 = 1'b0;
`ifdef GATE_BIST_EXHAUSTIVE_EN
      startx = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_stim", stim, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_pass", pass, 1'b0);
      check("rst_err", err_count, 8'h00);
      check("rst_ff", first_fail, 8'h00);
      @(negedge clk) reset = 1'b0;

      // good bank
      run_main(-1, cyc);
      check("good_busy0", busy_at0, 1'b1);
      check("good_lat", cyc, 54);
      check("good_pass", pass, 1'b1);
      check("good_err", err_count, 8'h00);
      check("good_ff", first_fail, 8'h00);
      check("good_busy", busy, 1'b0);
      check("good_stim_end", stim, 8'h7F);
      check("vec0", stim_log[0], 8'h00);
      check("vec1", stim_log[3], 8'hFF);
      check("vec2", stim_log[6], 8'h01);
      check("vec5", stim_log[15], 8'h08);
      check("vec9", stim_log[27], 8'h80);
      check("vec10", stim_log[30], 8'hFE);
      check("vec13", stim_log[39], 8'hF7);
      check("vec17", stim_log[51], 8'h7F);

      // stuck-at-0 on resp[3], started from DONE
      mode = 1;
      run_main(-1, cyc);
      check("sa0_done_clr", done_at0, 1'b0);
      check("sa0_busy0", busy_at0, 1'b1);
      check("sa0_lat", cyc, 54);
      check("sa0_pass", pass, 1'b0);
      check("sa0_err", err_count, 8'd9);
      check("sa0_ff", first_fail, 8'h00);

      // second start while busy is ignored
      mode = 0;
      run_main(10, cyc);
      check("ign_lat", cyc, 54);
      check("ign_pass", pass, 1'b1);
      check("ign_err", err_count, 8'h00);

      // async reset mid-run
      mode = 1;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      check("mid_busy", busy, 1'b1);
      check("mid_err_nz", (err_count != 8'h00), 1'b1);
      #1 reset = 1'b1;
      #1;
      check("ar_stim", stim, 8'h00);
      check("ar_busy", busy, 1'b0);
      check("ar_done", done, 1'b0);
      check("ar_pass", pass, 1'b0);
      check("ar_err", err_count, 8'h00);
      check("ar_ff", first_fail, 8'h00);
      @(negedge clk) reset = 1'b0;
      mode = 0;
      run_main(-1, cyc);
      check("ar_run_lat", cyc, 54);
      check("ar_run_pass", pass, 1'b1);

      // buffer bank, 4-bit saturating counter
      @(negedge clk) start4 = 1'b1;
      @(posedge clk);
      #1 start4 = 1'b0;
      cyc = 0;
      while (!done4 && cyc < 300) begin
         @(posedge clk);
         #1 cyc++;
      end
      check("buf_lat", cyc, 54);
      check("buf_err", err4, 4'hF);
      check("buf_pass", pass4, 1'b0);
      check("buf_ff", ff4, 8'h00);

`ifdef GATE_BIST_EXHAUSTIVE_EN
      @(negedge clk) startx = 1'b1;
      @(posedge clk);
      #1 startx = 1'b0;
      cyc = 0;
      logx[0] = stimx;
      while (!donex && cyc < 400) begin
         @(posedge clk);
         #1 cyc++;
         if (cyc < 128) logx[cyc] = stimx;
      end
      check("exh_lat", cyc, 78);
      check("exh_pass", passx, 1'b1);
      check("exh_err", errx, 8'h00);
      for (int j = 0; j < 16; j++) begin
         check($sformatf("exh_vec%0d", j), logx[3 * (10 + j)], j);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
